// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared FSM state encoding and address constants for mem_bridge
// The IO_ACC state exists only when MEM_BRIDGE_IO_EN is defined.
package mem_bridge_pkg;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
`ifdef MEM_BRIDGE_IO_EN
    IO_ACC   = 3'd5,
`endif
    DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/tri_buffer_16.sv
// rtl/tri_buffer_16.sv - 16-bit tri-state driver for the shared SRAM data bus
// Drives data_i onto bus_io while en_i is high, releases the bus otherwise.
module tri_buffer_16 (
  input  logic        en_i,
  input  logic [15:0] data_i,
  inout  wire  [15:0] bus_io
);

  assign bus_io = en_i ? data_i : 16'hzzzz;

endmodule

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - control-unit to async SRAM bridge with optional memory-mapped switch/hex I/O
// Optional feature: MEM_BRIDGE_IO_EN routes IO_ADDR to a one-cycle IO_ACC access instead of SRAM.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Rd_req,
  input  logic        Wr_req,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_out,
  output logic [15:0] Rd_data,
  output logic        Done,
  output logic        Busy,
  input  logic [15:0] S,
  output logic [15:0] Hex_data,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic        CE_N,
  output logic        UB_N,
  output logic        LB_N,
  output logic        OE_N,
  output logic        WE_N
);

  // Counter holds the remaining cycles of the current strobe, so it loads WAIT_CYCLES-1.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        io_access;
  logic        data_oe;

`ifdef MEM_BRIDGE_IO_EN
  logic        io_q, io_d;
  logic [15:0] hex_q, hex_d;

  assign io_access = io_q;
  assign Hex_data  = hex_q;
`else
  logic        unused_ok;

  assign io_access = 1'b0;
  assign Hex_data  = 16'h0000;
  assign unused_ok = ^{S, IO_ADDR, is_wr_q};
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      rd_data_q <= '0;
`ifdef MEM_BRIDGE_IO_EN
      io_q      <= 1'b0;
      hex_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      rd_data_q <= rd_data_d;
`ifdef MEM_BRIDGE_IO_EN
      io_q      <= io_d;
      hex_q     <= hex_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    rd_data_d = rd_data_q;
`ifdef MEM_BRIDGE_IO_EN
    io_d      = io_q;
    hex_d     = hex_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Wr_req || Rd_req) begin
          addr_d  = MAR;
          wdata_d = MDR_out;
          is_wr_d = Wr_req;
          cnt_d   = WAIT_LOAD;
          state_d = Wr_req ? WR_SETUP : RD_WAIT;
`ifdef MEM_BRIDGE_IO_EN
          io_d = (MAR == IO_ADDR);
          if (MAR == IO_ADDR) state_d = IO_ACC;
`endif
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rd_data_d = Data;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_SETUP: begin
        cnt_d   = WAIT_LOAD;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q == 4'd0) state_d = WR_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      WR_HOLD: state_d = DONE;
`ifdef MEM_BRIDGE_IO_EN
      IO_ACC: begin
        if (is_wr_q) hex_d     = wdata_q;
        else         rd_data_d = S;
        state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // I/O accesses keep the SRAM deselected through their DONE cycle as well.
  assign CE_N    = (state_q == IDLE) || io_access;
  assign UB_N    = CE_N;
  assign LB_N    = CE_N;
  assign OE_N    = (state_q != RD_WAIT);
  assign WE_N    = (state_q != WR_PULSE);
  assign data_oe = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);
  assign ADDR    = {4'b0000, addr_q};
  assign Busy    = (state_q != IDLE);
  assign Done    = (state_q == DONE);
  assign Rd_data = rd_data_q;

  tri_buffer_16 u_tri (
    .en_i   (data_oe),
    .data_i (wdata_q),
    .bus_io (Data)
  );

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - directed scoreboard bench for mem_bridge with a behavioural SRAM model
module tb_mem_bridge;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset, Rd_req, Wr_req;
  logic [15:0] MAR, MDR_out, S;
  logic [15:0] Rd_data, Hex_data;
  logic        Done, Busy, CE_N, UB_N, LB_N, OE_N, WE_N;
  logic [19:0] ADDR;
  wire  [15:0] Data;

  logic [15:0] sram     [0:65535];
  logic [15:0] ref_mem  [0:65535];
  logic [15:0] exp_q    [$];
  logic [15:0] last_rd;
  logic [15:0] exp_hex;
  int          n_checks = 0;
  int          n_fail   = 0;

  mem_bridge #(.WAIT_CYCLES(W), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .Rd_req(Rd_req), .Wr_req(Wr_req),
    .MAR(MAR), .MDR_out(MDR_out), .Rd_data(Rd_data), .Done(Done), .Busy(Busy),
    .S(S), .Hex_data(Hex_data), .ADDR(ADDR), .Data(Data),
    .CE_N(CE_N), .UB_N(UB_N), .LB_N(LB_N), .OE_N(OE_N), .WE_N(WE_N)
  );

  always #5 Clk = ~Clk;

  assign Data = (!CE_N && !OE_N) ? sram[ADDR[15:0]] : 16'hzzzz;

  always @(posedge WE_N) begin
    if (!CE_N) sram[ADDR[15:0]] = Data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_ce"}, {CE_N, UB_N, LB_N}, 3'b111);
    chk({tag, "_oe_we"}, {OE_N, WE_N}, 2'b11);
    chk({tag, "_drive"}, dut.data_oe, 0);
  endtask

  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input logic poke_rd);
    int   n, oe_cnt, we_cnt, ce_lo, overlap, data_bad, lat;
    logic io;
    n = 1; oe_cnt = 0; we_cnt = 0; ce_lo = 0; overlap = 0; data_bad = 0;
`ifdef MEM_BRIDGE_IO_EN
    io = (addr == 16'hFFFF);
`else
    io = 1'b0;
`endif
    lat = io ? 2 : (wr ? W + 3 : W + 1);
    if (wr) begin
      if (io) exp_hex = wdata;
      else    ref_mem[addr] = wdata;
    end else begin
      exp_q.push_back(io ? S : ref_mem[addr]);
    end
    @(negedge Clk);
    Rd_req = rd; Wr_req = wr; MAR = addr; MDR_out = wdata;
    @(posedge Clk); #1;
    Rd_req = 1'b0; Wr_req = 1'b0; MAR = ~addr; MDR_out = ~wdata;
    if (!io) chk({tag, "_addr"}, ADDR, {4'b0000, addr});
    forever begin
      if (!OE_N) oe_cnt++;
      if (!WE_N) we_cnt++;
      if (!CE_N) ce_lo++;
      if (!OE_N && !WE_N) overlap++;
      if (wr && !io && n <= W + 2 && Data !== wdata) data_bad++;
      Rd_req = poke_rd && (n == 2);
      if (Done || n >= 40) break;
      @(posedge Clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_oe_cycles"}, oe_cnt, (!wr && !io) ? W : 0);
    chk({tag, "_we_cycles"}, we_cnt, (wr && !io) ? W : 0);
    chk({tag, "_ce_cycles"}, ce_lo, io ? 0 : lat);
    chk({tag, "_oe_we_overlap"}, overlap, 0);
    if (wr && !io) chk({tag, "_wdata_stable"}, data_bad, 0);
    if (!wr && Done && exp_q.size() > 0) begin
      last_rd = exp_q.pop_front();
      chk({tag, "_rd_data"}, Rd_data, last_rd);
    end else begin
      chk({tag, "_rd_hold"}, Rd_data, last_rd);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk); #1;
      check_idle($sformatf("%s_after%0d", tag, i));
    end
  endtask

  initial begin
    int n, done_at0, done_at1, dones;
    Reset = 1'b1; Rd_req = 1'b0; Wr_req = 1'b0; MAR = '0; MDR_out = '0; S = 16'h00A5;
    last_rd = 16'h0000; exp_hex = 16'h0000;
    sram[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
    repeat (2) @(posedge Clk);
    #1;
    check_idle("reset");
    chk("reset_rd_data", Rd_data, 16'h0000);
    chk("reset_hex", Hex_data, 16'h0000);
    @(negedge Clk); Reset = 1'b0;

    run_access("rd_beef", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    run_access("wr_1234", 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0);
    run_access("rd_1234", 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    run_access("rdwr_both", 1'b1, 1'b1, 16'h0030, 16'h5678, 1'b1);
    run_access("rd_5678", 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);

    // Held Rd_req: second read accepted in the IDLE cycle right after DONE.
    exp_q.push_back(ref_mem[16'h0010]);
    exp_q.push_back(ref_mem[16'h0010]);
    @(negedge Clk); Rd_req = 1'b1; MAR = 16'h0010;
    @(posedge Clk); #1;
    n = 1; dones = 0; done_at0 = 0; done_at1 = 0;
    while (n <= 12) begin
      if (Done) begin
        if (dones == 0) done_at0 = n; else done_at1 = n;
        dones++;
        if (exp_q.size() > 0) chk($sformatf("b2b_rd_data%0d", dones), Rd_data, exp_q.pop_front());
        if (dones == 2) Rd_req = 1'b0;
      end
      if (dones == 2) break;
      @(posedge Clk); #1;
      n++;
    end
    Rd_req = 1'b0;
    chk("b2b_first_done", done_at0, W + 1);
    chk("b2b_second_done", done_at1, 2 * (W + 1) + 1);
    last_rd = ref_mem[16'h0010];
    repeat (2) @(posedge Clk);
    #1;
    check_idle("b2b_idle");

`ifdef MEM_BRIDGE_IO_EN
    run_access("io_rd", 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
    run_access("io_wr", 1'b0, 1'b1, 16'hFFFF, 16'h0042, 1'b0);
    chk("io_hex", Hex_data, 16'h0042);
`else
    run_access("ffff_wr", 1'b0, 1'b1, 16'hFFFF, 16'h0042, 1'b0);
    run_access("ffff_rd", 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
    chk("hex_tied", Hex_data, 16'h0000);
`endif

    // Reset during WR_PULSE aborts cleanly with no Done.
    @(negedge Clk); Wr_req = 1'b1; MAR = 16'h0040; MDR_out = 16'h9999;
    @(posedge Clk); #1;
    Wr_req = 1'b0;
    @(posedge Clk); #1;
    chk("midrst_in_pulse", WE_N, 0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check_idle("midrst");
    chk("midrst_rd_data", Rd_data, 16'h0000);
    Reset = 1'b0;
    last_rd = 16'h0000;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (Done || Busy) dones++;
      @(posedge Clk); #1;
    end
    chk("midrst_no_done", dones, 0);

    // Reset beats a simultaneous write request.
    @(negedge Clk); Reset = 1'b1; Wr_req = 1'b1; MAR = 16'h0050; MDR_out = 16'h7777;
    @(posedge Clk); #1;
    check_idle("rst_prio");
    @(negedge Clk); Reset = 1'b0; Wr_req = 1'b0;

    run_access("rd_after_rst", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
